// File: rtl/z_out_serializer.sv
// z_out_serializer: buffers Z results in a FIFO and sends them LSB-first on a UART-style line.
// Define Z_SER_PARITY_EN to insert an even-parity bit between DATA and STOP.
module z_out_serializer #(
    parameter int DATA_W       = 4,
    parameter int DEPTH        = 4,
    parameter int CLKS_PER_BIT = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] z_in,
    input  logic              z_valid,
    output logic              tx,
    output logic              busy,
    output logic              fifo_full,
    output logic              overflow
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int BW = $clog2(DATA_W + 1);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     cyc_q, cyc_d;
    logic [BW-1:0]     bit_q, bit_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic [AW-1:0]     wr_q, wr_d, rd_q, rd_d;
    logic [AW:0]       cnt_q, cnt_d;
    logic              full_q, full_d, ovf_q, ovf_d;
    logic [DATA_W-1:0] mem_q [DEPTH];
    logic              push, pop, bit_end;
`ifdef Z_SER_PARITY_EN
    logic              par_q, par_d;
`endif

    always_comb begin
        state_d = state_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        pop     = 1'b0;
        bit_end = cyc_q == CW'(CLKS_PER_BIT - 1);
        cyc_d   = (state_q == IDLE || bit_end) ? '0 : cyc_q + CW'(1);
        case (state_q)
            IDLE: begin
                pop     = cnt_q != '0;
                state_d = pop ? START : IDLE;
            end
            START: state_d = bit_end ? DATA : START;
            DATA: if (bit_end) begin
                shift_d = shift_q >> 1;
                bit_d   = bit_q + BW'(1);
`ifdef Z_SER_PARITY_EN
                if (bit_q == BW'(DATA_W - 1)) state_d = PARITY;
`else
                if (bit_q == BW'(DATA_W - 1)) state_d = STOP;
`endif
            end
            PARITY: state_d = bit_end ? STOP : PARITY;
            STOP: if (bit_end) begin
                // A waiting word starts its frame immediately, keeping busy high.
                pop     = cnt_q != '0;
                state_d = pop ? START : IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (pop) begin
            shift_d = mem_q[rd_q];
            bit_d   = '0;
        end
        push   = z_valid && (!full_q || pop);
        ovf_d  = ovf_q || (z_valid && full_q && !pop);
        wr_d   = wr_q + AW'(push);
        rd_d   = rd_q + AW'(pop);
        cnt_d  = cnt_q + (AW+1)'(push) - (AW+1)'(pop);
        full_d = cnt_d == (AW+1)'(DEPTH);
    end

`ifdef Z_SER_PARITY_EN
    assign par_d = pop ? ^mem_q[rd_q] : par_q;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cyc_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            wr_q    <= '0;
            rd_q    <= '0;
            cnt_q   <= '0;
            full_q  <= 1'b0;
            ovf_q   <= 1'b0;
`ifdef Z_SER_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cyc_q   <= cyc_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            cnt_q   <= cnt_d;
            full_q  <= full_d;
            ovf_q   <= ovf_d;
`ifdef Z_SER_PARITY_EN
            par_q   <= par_d;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_q] <= z_in;
    end

    always_comb begin
        tx = 1'b1;
        case (state_q)
            START:   tx = 1'b0;
            DATA:    tx = shift_q[0];
`ifdef Z_SER_PARITY_EN
            PARITY:  tx = par_q;
`endif
            default: tx = 1'b1;
        endcase
    end

    assign busy      = state_q != IDLE;
    assign fifo_full = full_q;
    assign overflow  = ovf_q;
endmodule

// File: tb/tb_z_out_serializer.sv
// tb_z_out_serializer: directed checks of the Z result serializer (frame shape, FIFO, overflow, reset).
module tb_z_out_serializer;
    localparam int DW  = 4;
    localparam int CPB = 4;
`ifdef Z_SER_PARITY_EN
    localparam int P = 1;
`else
    localparam int P = 0;
`endif
    localparam int FL = (2 + DW + P) * CPB;

    logic       clk = 1'b0, rst_n = 1'b0, z_valid = 1'b0;
    logic [3:0] z_in = 4'h0;
    logic       tx, busy, fifo_full, overflow;
    int         checks = 0, errors = 0;
    logic [3:0] words [8];
    int         nw = 0;

    z_out_serializer #(.DATA_W(DW), .DEPTH(4), .CLKS_PER_BIT(CPB)) dut (
        .clk(clk), .rst_n(rst_n), .z_in(z_in), .z_valid(z_valid),
        .tx(tx), .busy(busy), .fifo_full(fifo_full), .overflow(overflow)
    );

    always #5 clk = ~clk;

    function automatic logic exp_tx(input logic [3:0] w, input int i);
        int b;
        b = i / CPB;
        if (b == 0) return 1'b0;
        if (b <= DW) return w[b-1];
        if (P == 1 && b == DW + 1) return ^w;
        return 1'b1;
    endfunction

    // {busy, tx} expected at negedge t when frames for words[0..nw-1] run back-to-back from s0.
    function automatic logic [1:0] exp_line(input int t, input int s0);
        int k;
        if (t < s0) return 2'b01;
        k = (t - s0) / FL;
        if (k >= nw) return 2'b01;
        return {1'b1, exp_tx(words[k], (t - s0) % FL)};
    endfunction

    task automatic test_reset();
        rst_n = 1'b0;
        z_valid = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({tx, busy, fifo_full, overflow} !== 4'b1000) begin
            errors++;
            $display("FAIL reset: got tx/busy/full/ovf=%b expected 1000", {tx, busy, fifo_full, overflow});
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_single(input logic [3:0] w);
        words[0] = w;
        nw = 1;
        for (int n = 0; n < FL + 8; n++) begin
            checks++;
            if ({busy, tx} !== exp_line(n, 2)) begin
                errors++;
                $display("FAIL single_%h cycle %0d: got busy,tx=%b expected %b", w, n, {busy, tx}, exp_line(n, 2));
            end
            z_valid = (n == 0);
            z_in = w;
            @(negedge clk);
        end
    endtask

    task automatic test_overflow();
        for (int i = 0; i < 5; i++) words[i] = 4'(i + 1);
        nw = 5;
        for (int n = 0; n < 5 * FL + 8; n++) begin
            checks++;
            if ({busy, tx} !== exp_line(n, 2)) begin
                errors++;
                $display("FAIL overflow_line cycle %0d: got busy,tx=%b expected %b", n, {busy, tx}, exp_line(n, 2));
            end
            if (n == 5) begin
                checks++;
                if ({fifo_full, overflow} !== 2'b10) begin
                    errors++;
                    $display("FAIL overflow_full: got full,ovf=%b expected 10", {fifo_full, overflow});
                end
            end
            if (n == 6 || n == 5 * FL + 7) begin
                checks++;
                if (overflow !== 1'b1) begin
                    errors++;
                    $display("FAIL overflow_sticky cycle %0d: got %b expected 1", n, overflow);
                end
            end
            z_valid = (n < 6);
            z_in = 4'(n + 1);
            @(negedge clk);
        end
    endtask

    task automatic test_back_to_back();
        words[0] = 4'h3;
        words[1] = 4'hC;
        nw = 2;
        for (int n = 0; n < 2 * FL + 8; n++) begin
            checks++;
            if ({busy, tx} !== exp_line(n, 2)) begin
                errors++;
                $display("FAIL back_to_back cycle %0d: got busy,tx=%b expected %b", n, {busy, tx}, exp_line(n, 2));
            end
            z_valid = (n < 2);
            z_in = (n == 0) ? 4'h3 : 4'hC;
            @(negedge clk);
        end
    endtask

    task automatic test_push_on_pop();
        for (int i = 0; i < 6; i++) words[i] = 4'(i + 1);
        nw = 6;
        for (int n = 0; n < 6 * FL + 8; n++) begin
            checks++;
            if ({busy, tx} !== exp_line(n, 2)) begin
                errors++;
                $display("FAIL push_on_pop_line cycle %0d: got busy,tx=%b expected %b", n, {busy, tx}, exp_line(n, 2));
            end
            if (n == 2 + FL - 1 || n == 2 + FL || n == 6 * FL + 7) begin
                checks++;
                if ({fifo_full, overflow} !== ((n == 6 * FL + 7) ? 2'b00 : 2'b10)) begin
                    errors++;
                    $display("FAIL push_on_pop_flags cycle %0d: got full,ovf=%b expected %b", n, {fifo_full, overflow},
                             (n == 6 * FL + 7) ? 2'b00 : 2'b10);
                end
            end
            z_valid = (n < 5) || (n == 2 + FL - 1);
            z_in = (n < 5) ? 4'(n + 1) : 4'h6;
            @(negedge clk);
        end
    endtask

    task automatic test_reset_mid_frame();
        words[0] = 4'hA;
        words[1] = 4'h5;
        nw = 2;
        for (int n = 0; n < 2 + CPB + 2 * CPB + 1; n++) begin
            checks++;
            if ({busy, tx} !== exp_line(n, 2)) begin
                errors++;
                $display("FAIL mid_reset_pre cycle %0d: got busy,tx=%b expected %b", n, {busy, tx}, exp_line(n, 2));
            end
            z_valid = (n < 2);
            z_in = (n == 0) ? 4'hA : 4'h5;
            @(negedge clk);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({tx, busy, fifo_full} !== 3'b100) begin
            errors++;
            $display("FAIL mid_reset_now: got tx/busy/full=%b expected 100", {tx, busy, fifo_full});
        end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            checks++;
            if ({busy, tx} !== 2'b01) begin
                errors++;
                $display("FAIL mid_reset_after cycle %0d: got busy,tx=%b expected 01", n, {busy, tx});
            end
        end
    endtask

    initial begin
        test_reset();
        test_single(4'hA);
        test_reset();
        test_overflow();
        test_reset();
        test_back_to_back();
        test_reset();
        test_reset_mid_frame();
        test_reset();
        test_push_on_pop();
        test_reset();
        test_single(4'h7);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
